regfile: RTL

//  RV32I integer register file: the responder to the ID stage's rs1/rs2 read requests and the sink for writeback.
//  - 2 combinational read ports, 1 handshaked write port. x0 is hardwired to zero.
//  - After reset, a clear sequencer zeroes x1..x31 before the file accepts writes.

---
 rtl/regfile.sv | 126 ++++++++++++
 1 files changed

// File: rtl/regfile.sv
// RV32I integer register file: two combinational read ports, one handshaked write port, x0 hardwired to zero.
// A post-reset clear sequencer zeroes x1..x31 before writes are accepted. Optional write-through: REGFILE_BYPASS_EN.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_sys_i,
    input  logic [$clog2(NREG)-1:0] rst1_addr_i,
    input  logic [$clog2(NREG)-1:0] rst2_addr_i,
    output logic [XLEN-1:0]         rst1_o,
    output logic [XLEN-1:0]         rst2_o,
    input  logic                    wb_valid_i,
    output logic                    wb_ready_o,
    input  logic [$clog2(NREG)-1:0] rd_addr_i,
    input  logic [XLEN-1:0]         rd_data_i,
    output logic                    busy_o,
    output logic [31:0]             wb_cnt_o
);
    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
    logic            busy_reg, busy_next;
    logic            ready_reg, ready_next;
    logic [31:0]     wb_cnt_reg, wb_cnt_next;

    logic            wr_fire;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    logic [XLEN-1:0] mem [NREG];

    assign wr_fire = wb_valid_i && ready_reg && (state_reg == ST_RUN);

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= AW'(1);
            busy_reg    <= 1'b1;
            ready_reg   <= 1'b0;
            wb_cnt_reg  <= 32'd0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            busy_reg    <= busy_next;
            ready_reg   <= ready_next;
            wb_cnt_reg  <= wb_cnt_next;
        end
    end

    // Clear sequencer and writeback share the single memory write port.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        busy_next    = busy_reg;
        ready_next   = ready_reg;
        wb_cnt_next  = wb_cnt_reg;
        mem_we       = 1'b0;
        mem_waddr    = rd_addr_i;
        mem_wdata    = rd_data_i;
        case (state_reg)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_cnt_reg;
                mem_wdata    = '0;
                clr_cnt_next = clr_cnt_reg + AW'(1);
                if (clr_cnt_reg == LAST_REG) begin
                    state_next = ST_RUN;
                    busy_next  = 1'b0;
                    ready_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_fire) begin
                    wb_cnt_next = wb_cnt_reg + 32'd1;
                    mem_we      = (rd_addr_i != '0);
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Writes presented while reset is sampled are discarded.
    always_ff @(posedge clk_sys_i) begin
        if (mem_we && !rst_sys_i) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [1:0][AW-1:0]   rd_port_addr;
    logic [1:0][XLEN-1:0] rd_port_data;

    assign rd_port_addr[0] = rst1_addr_i;
    assign rd_port_addr[1] = rst2_addr_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [XLEN-1:0] stored;
            assign stored = (state_reg == ST_CLEAR || rd_port_addr[gi] == '0) ? '0 : mem[rd_port_addr[gi]];
`ifdef REGFILE_BYPASS_EN
            // Write-through: an accepted non-x0 write is visible in its own cycle.
            assign rd_port_data[gi] = (wr_fire && rd_addr_i != '0 && rd_addr_i == rd_port_addr[gi])
                                      ? rd_data_i : stored;
`else
            assign rd_port_data[gi] = stored;
`endif
        end
    endgenerate

    assign rst1_o     = rd_port_data[0];
    assign rst2_o     = rd_port_data[1];
    assign busy_o     = busy_reg;
    assign wb_ready_o = ready_reg;
    assign wb_cnt_o   = wb_cnt_reg;

endmodule
